// File: rtl/csr_access_controller_pkg.sv
// Shared definitions for the CSR access controller: Zicsr encodings, FSM states,
// CSR address map and index classification helpers.
package csr_access_controller_pkg;

    localparam int DEFAULT_XLEN           = 32;
    localparam int DEFAULT_CSR_ADDR_WIDTH = 12;

    localparam logic [2:0] F3_RW  = 3'b001;
    localparam logic [2:0] F3_RS  = 3'b010;
    localparam logic [2:0] F3_RC  = 3'b011;
    localparam logic [2:0] F3_RWI = 3'b101;
    localparam logic [2:0] F3_RSI = 3'b110;
    localparam logic [2:0] F3_RCI = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    localparam logic [DEFAULT_CSR_ADDR_WIDTH-1:0] CSR_ALUCSR    = 12'h7C0;
    localparam logic [DEFAULT_CSR_ADDR_WIDTH-1:0] CSR_MULCSR    = 12'h7C1;
    localparam logic [DEFAULT_CSR_ADDR_WIDTH-1:0] CSR_DIVCSR    = 12'h7C2;
    localparam logic [DEFAULT_CSR_ADDR_WIDTH-1:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [DEFAULT_CSR_ADDR_WIDTH-1:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [DEFAULT_CSR_ADDR_WIDTH-1:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [DEFAULT_CSR_ADDR_WIDTH-1:0] CSR_MINSTRETH = 12'hB82;

    function automatic logic csr_is_read_only(input logic [DEFAULT_CSR_ADDR_WIDTH-1:0] idx);
        return (idx == CSR_MCYCLE)  || (idx == CSR_MINSTRET) ||
               (idx == CSR_MCYCLEH) || (idx == CSR_MINSTRETH);
    endfunction

    function automatic logic csr_is_known(input logic [DEFAULT_CSR_ADDR_WIDTH-1:0] idx);
        return (idx == CSR_ALUCSR) || (idx == CSR_MULCSR) || (idx == CSR_DIVCSR) ||
               csr_is_read_only(idx);
    endfunction

    // 000 and 100 are the only undefined Zicsr encodings.
    function automatic logic funct3_is_legal(input logic [2:0] f3);
        return f3[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/csr_access_controller_if.sv
// CSR file port: read/write strobes, indices and data between the
// access controller (master) and the CSR file (slave).
interface csr_access_controller_if
    import csr_access_controller_pkg::*;
#(
    parameter int XLEN           = DEFAULT_XLEN,
    parameter int CSR_ADDR_WIDTH = DEFAULT_CSR_ADDR_WIDTH
);
    logic                      read_enable_csr;
    logic [CSR_ADDR_WIDTH-1:0] csr_read_index;
    logic [XLEN-1:0]           csr_read_data;
    logic                      write_enable_csr;
    logic [CSR_ADDR_WIDTH-1:0] csr_write_index;
    logic [XLEN-1:0]           csr_write_data;

    modport master (
        output read_enable_csr, csr_read_index,
        output write_enable_csr, csr_write_index, csr_write_data,
        input  csr_read_data
    );

    modport slave (
        input  read_enable_csr, csr_read_index,
        input  write_enable_csr, csr_write_index, csr_write_data,
        output csr_read_data
    );
endinterface

// File: rtl/csr_modify_unit.sv
// Combinational Zicsr read-modify-write: op 01 write, 10 set bits, 11 clear bits.
module csr_modify_unit #(
    parameter int XLEN = 32
) (
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] src,
    input  logic [XLEN-1:0] old_data,
    output logic [XLEN-1:0] new_data
);
    always_comb begin
        new_data = src;
        case (op)
            2'b10:   new_data = old_data | src;
            2'b11:   new_data = old_data & ~src;
            default: new_data = src;
        endcase
    end
endmodule

// File: rtl/csr_access_controller.sv
// Zicsr executor: runs each CSR instruction as a read / write / respond sequence
// against the CSR file and returns the old value for rd.
//
// state    | meaning
// ST_IDLE  | waiting for start; decode and legality check happen on accept
// ST_READ  | read strobe high, old value sampled at cycle end
// ST_WRITE | write strobe high for the whole cycle with the modified value
// ST_RESP  | done pulse, rd_data valid, illegal flagged if rejected
module csr_access_controller
    import csr_access_controller_pkg::*;
#(
    parameter int XLEN           = DEFAULT_XLEN,
    parameter int CSR_ADDR_WIDTH = DEFAULT_CSR_ADDR_WIDTH
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      kill,
    input  logic [2:0]                funct3,
    input  logic [CSR_ADDR_WIDTH-1:0] csr_index,
    input  logic [4:0]                rs1_index,
    input  logic [4:0]                rd_index,
    input  logic [XLEN-1:0]           rs1_data,
    output logic                      busy,
    output logic                      done,
    output logic                      illegal,
    output logic [XLEN-1:0]           rd_data,
    csr_access_controller_if.master   csr_bus
);
    state_e state_q, state_d;

    logic [1:0]                op_q;
    logic [XLEN-1:0]           src_q;
    logic [XLEN-1:0]           old_q;
    logic                      do_write_q;
    logic [CSR_ADDR_WIDTH-1:0] index_q;

    logic                      read_en_q, write_en_q;
    logic [XLEN-1:0]           write_data_q;

    logic                      busy_d, done_d, illegal_d, read_en_d, write_en_d;
    logic [XLEN-1:0]           write_data_d, rd_data_d;

    logic            accept;
    logic [XLEN-1:0] src_in;
    logic            write_form;
    logic            do_read_in, do_write_in, illegal_in;
    logic [1:0]      mod_op;
    logic [XLEN-1:0] mod_src, mod_old, mod_new;

    assign accept      = start && !kill;
    assign src_in      = funct3[2] ? {{(XLEN-5){1'b0}}, rs1_index} : rs1_data;
    assign write_form  = funct3[1:0] == 2'b01;
    assign do_read_in  = !(write_form && rd_index == 5'd0);
    assign do_write_in = write_form || rs1_index != 5'd0;
    assign illegal_in  = !funct3_is_legal(funct3) || !csr_is_known(csr_index) ||
                         (do_write_in && csr_is_read_only(csr_index));

    // Write-only requests skip READ, so the modifier sees the live inputs and old=0.
    assign mod_op  = (state_q == ST_IDLE) ? funct3[1:0] : op_q;
    assign mod_src = (state_q == ST_IDLE) ? src_in : src_q;
    assign mod_old = (state_q == ST_READ) ? csr_bus.csr_read_data : '0;

    csr_modify_unit #(.XLEN(XLEN)) u_modify (
        .op       (mod_op),
        .src      (mod_src),
        .old_data (mod_old),
        .new_data (mod_new)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            illegal      <= 1'b0;
            read_en_q    <= 1'b0;
            write_en_q   <= 1'b0;
            write_data_q <= '0;
            rd_data      <= '0;
        end else begin
            state_q      <= state_d;
            busy         <= busy_d;
            done         <= done_d;
            illegal      <= illegal_d;
            read_en_q    <= read_en_d;
            write_en_q   <= write_en_d;
            write_data_q <= write_data_d;
            rd_data      <= rd_data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (illegal_in)      state_d = ST_RESP;
                    else if (do_read_in) state_d = ST_READ;
                    else                 state_d = ST_WRITE;
                end
            end
            ST_READ: begin
                if (kill)            state_d = ST_IDLE;
                else if (do_write_q) state_d = ST_WRITE;
                else                 state_d = ST_RESP;
            end
            ST_WRITE: state_d = ST_RESP;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Outputs are computed from the next state so they come straight off flops.
    always_comb begin
        busy_d       = state_d != ST_IDLE;
        done_d       = state_d == ST_RESP;
        illegal_d    = (state_d == ST_RESP) && (state_q == ST_IDLE);
        read_en_d    = state_d == ST_READ;
        write_en_d   = state_d == ST_WRITE;
        write_data_d = write_en_d ? mod_new : write_data_q;
        rd_data_d    = rd_data;
        if (done_d) begin
            case (state_q)
                ST_IDLE: rd_data_d = '0;
                ST_READ: rd_data_d = csr_bus.csr_read_data;
                default: rd_data_d = old_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            op_q       <= 2'b00;
            src_q      <= '0;
            old_q      <= '0;
            do_write_q <= 1'b0;
            index_q    <= '0;
        end else if (state_q == ST_IDLE && accept) begin
            op_q       <= funct3[1:0];
            src_q      <= src_in;
            old_q      <= '0;
            do_write_q <= do_write_in;
            index_q    <= csr_index;
        end else if (state_q == ST_READ) begin
            old_q      <= csr_bus.csr_read_data;
        end
    end

    assign csr_bus.read_enable_csr  = read_en_q;
    assign csr_bus.csr_read_index   = index_q;
    assign csr_bus.write_enable_csr = write_en_q;
    assign csr_bus.csr_write_index  = index_q;
    assign csr_bus.csr_write_data   = write_data_q;

endmodule

// File: tb/tb_csr_access_controller.sv
// Directed bench for csr_access_controller with a small behavioural CSR file.
module tb_csr_access_controller;
    import csr_access_controller_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        kill = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [11:0] csr_index = 12'h000;
    logic [4:0]  rs1_index = 5'd0;
    logic [4:0]  rd_index = 5'd0;
    logic [31:0] rs1_data = 32'h0;
    logic        busy, done, illegal;
    logic [31:0] rd_data;

    int total = 0;
    int bad = 0;
    int wcount = 0;

    logic [31:0] alu_q = 32'h0;
    logic [31:0] mul_q = 32'h0;
    logic [31:0] div_q = 32'h0;

    logic        s_re   [0:7];
    logic        s_we   [0:7];
    logic        s_done [0:7];
    logic        s_ill  [0:7];
    logic        s_busy [0:7];
    logic [31:0] s_wd   [0:7];
    logic [31:0] s_rdd  [0:7];

    csr_access_controller_if #(.XLEN(32), .CSR_ADDR_WIDTH(12)) bus ();

    csr_access_controller dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .kill      (kill),
        .funct3    (funct3),
        .csr_index (csr_index),
        .rs1_index (rs1_index),
        .rd_index  (rd_index),
        .rs1_data  (rs1_data),
        .busy      (busy),
        .done      (done),
        .illegal   (illegal),
        .rd_data   (rd_data),
        .csr_bus   (bus)
    );

    always #5 clk = ~clk;

    always_comb begin
        bus.csr_read_data = 32'h0;
        case (bus.csr_read_index)
            CSR_ALUCSR:   bus.csr_read_data = alu_q;
            CSR_MULCSR:   bus.csr_read_data = mul_q;
            CSR_DIVCSR:   bus.csr_read_data = div_q;
            CSR_MCYCLE:   bus.csr_read_data = 32'h0000_1234;
            CSR_MINSTRET: bus.csr_read_data = 32'h0000_0042;
            default:      bus.csr_read_data = 32'h0;
        endcase
    end

    always @(negedge clk) begin
        if (bus.write_enable_csr) begin
            wcount++;
            case (bus.csr_write_index)
                CSR_ALUCSR: alu_q = bus.csr_write_data;
                CSR_MULCSR: mul_q = bus.csr_write_data;
                CSR_DIVCSR: div_q = bus.csr_write_data;
                default: ;
            endcase
        end
    end

    // Caller is #1 after a posedge with the DUT idle. Samples cycles 1..n after accept.
    task automatic run_req(input logic [2:0] f3, input logic [11:0] idx, input logic [4:0] r1,
                           input logic [4:0] rd, input logic [31:0] d1, input int n,
                           input int kill_at, input int rst_at, input int restart_at);
        start = 1'b1; funct3 = f3; csr_index = idx; rs1_index = r1; rd_index = rd; rs1_data = d1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= n; c++) begin
            s_re[c]   = bus.read_enable_csr;
            s_we[c]   = bus.write_enable_csr;
            s_wd[c]   = bus.csr_write_data;
            s_done[c] = done;
            s_ill[c]  = illegal;
            s_busy[c] = busy;
            s_rdd[c]  = rd_data;
            kill  = (c == kill_at);
            reset = !(c == rst_at);
            if (c == restart_at) begin
                start = 1'b1; funct3 = F3_RW; csr_index = CSR_ALUCSR;
                rs1_index = 5'd9; rd_index = 5'd1; rs1_data = 32'hDEAD_BEEF;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
        end
        kill = 1'b0; reset = 1'b1; start = 1'b0;
    endtask

    task automatic wr_csr(input logic [11:0] idx, input logic [31:0] val);
        run_req(F3_RW, idx, 5'd1, 5'd0, val, 3, 0, 0, 0);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({busy, done, illegal, bus.read_enable_csr, bus.write_enable_csr} !== 5'b0) begin
            bad++; $display("FAIL reset_ctrl got=%b exp=00000",
                {busy, done, illegal, bus.read_enable_csr, bus.write_enable_csr});
        end
        total++;
        if (rd_data !== 32'h0) begin
            bad++; $display("FAIL reset_rd_data got=%h exp=0", rd_data);
        end
        total++;
        if ({bus.csr_read_index, bus.csr_write_index, bus.csr_write_data} !== 56'h0) begin
            bad++; $display("FAIL reset_bus got=%h/%h/%h exp=0", bus.csr_read_index,
                bus.csr_write_index, bus.csr_write_data);
        end
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_csrrw();
        wr_csr(CSR_ALUCSR, 32'h0);
        run_req(F3_RW, CSR_ALUCSR, 5'd2, 5'd5, 32'hA5A5_0F0F, 4, 0, 0, 0);
        total++;
        if ({s_re[1], s_we[1], s_re[2], s_we[2]} !== 4'b1001) begin
            bad++; $display("FAIL rw_strobes got=%b exp=1001", {s_re[1], s_we[1], s_re[2], s_we[2]});
        end
        total++;
        if (s_wd[2] !== 32'hA5A5_0F0F) begin
            bad++; $display("FAIL rw_wdata got=%h exp=a5a50f0f", s_wd[2]);
        end
        total++;
        if ({s_done[2], s_done[3], s_ill[3]} !== 3'b010) begin
            bad++; $display("FAIL rw_done got=%b exp=010", {s_done[2], s_done[3], s_ill[3]});
        end
        total++;
        if (s_rdd[3] !== 32'h0) begin
            bad++; $display("FAIL rw_rd_data got=%h exp=0", s_rdd[3]);
        end
        total++;
        if ({s_busy[1], s_busy[2], s_busy[3], s_busy[4]} !== 4'b1110) begin
            bad++; $display("FAIL rw_busy got=%b exp=1110", {s_busy[1], s_busy[2], s_busy[3], s_busy[4]});
        end
        total++;
        if (alu_q !== 32'hA5A5_0F0F) begin
            bad++; $display("FAIL rw_csr_value got=%h exp=a5a50f0f", alu_q);
        end
    endtask

    task automatic test_csrrs();
        wr_csr(CSR_MULCSR, 32'h0000_00F0);
        run_req(F3_RS, CSR_MULCSR, 5'd3, 5'd4, 32'h0000_000F, 4, 0, 0, 0);
        total++;
        if ({s_we[2], s_wd[2]} !== {1'b1, 32'h0000_00FF}) begin
            bad++; $display("FAIL rs_write got=%b/%h exp=1/000000ff", s_we[2], s_wd[2]);
        end
        total++;
        if ({s_done[3], s_rdd[3]} !== {1'b1, 32'h0000_00F0}) begin
            bad++; $display("FAIL rs_result got=%b/%h exp=1/000000f0", s_done[3], s_rdd[3]);
        end
    endtask

    task automatic test_csrrs_x0();
        int w0;
        w0 = wcount;
        run_req(F3_RS, CSR_MULCSR, 5'd0, 5'd4, 32'h0000_000F, 4, 0, 0, 0);
        total++;
        if ({s_re[1], s_done[2], s_done[3]} !== 3'b110) begin
            bad++; $display("FAIL rs_x0_timing got=%b exp=110", {s_re[1], s_done[2], s_done[3]});
        end
        total++;
        if ({s_we[1], s_we[2], s_we[3], s_we[4]} !== 4'b0 || wcount !== w0) begin
            bad++; $display("FAIL rs_x0_nowrite got=%b writes=%0d exp=0000 writes=%0d",
                {s_we[1], s_we[2], s_we[3], s_we[4]}, wcount, w0);
        end
        total++;
        if (s_rdd[2] !== 32'h0000_00FF) begin
            bad++; $display("FAIL rs_x0_rd_data got=%h exp=000000ff", s_rdd[2]);
        end
    endtask

    task automatic test_csrrci();
        wr_csr(CSR_DIVCSR, 32'hFFFF_FFFF);
        run_req(F3_RCI, CSR_DIVCSR, 5'h1F, 5'd6, 32'h0, 4, 0, 0, 0);
        total++;
        if (s_wd[2] !== 32'hFFFF_FFE0) begin
            bad++; $display("FAIL rci_wdata got=%h exp=ffffffe0", s_wd[2]);
        end
        total++;
        if ({s_done[3], s_rdd[3]} !== {1'b1, 32'hFFFF_FFFF}) begin
            bad++; $display("FAIL rci_result got=%b/%h exp=1/ffffffff", s_done[3], s_rdd[3]);
        end
        total++;
        if (div_q !== 32'hFFFF_FFE0) begin
            bad++; $display("FAIL rci_csr_value got=%h exp=ffffffe0", div_q);
        end
    endtask

    task automatic test_illegal();
        logic [2:0]  f3s  [0:3];
        logic [11:0] idxs [0:3];
        logic [4:0]  r1s  [0:3];
        int w0;
        f3s[0] = F3_RW;  idxs[0] = CSR_MCYCLE;    r1s[0] = 5'd1;
        f3s[1] = 3'b100; idxs[1] = CSR_ALUCSR;    r1s[1] = 5'd1;
        f3s[2] = F3_RW;  idxs[2] = 12'h7C7;       r1s[2] = 5'd1;
        f3s[3] = F3_RSI; idxs[3] = CSR_MINSTRETH; r1s[3] = 5'd3;
        for (int k = 0; k < 4; k++) begin
            w0 = wcount;
            run_req(f3s[k], idxs[k], r1s[k], 5'd7, 32'h1234_5678, 3, 0, 0, 0);
            total++;
            if ({s_done[1], s_ill[1], s_done[2], s_ill[2], s_busy[2]} !== 5'b11000) begin
                bad++; $display("FAIL illegal_%0d_flags got=%b exp=11000", k,
                    {s_done[1], s_ill[1], s_done[2], s_ill[2], s_busy[2]});
            end
            total++;
            if ({s_re[1], s_we[1], s_re[2], s_we[2]} !== 4'b0 || wcount !== w0 || s_rdd[1] !== 32'h0) begin
                bad++; $display("FAIL illegal_%0d_side got=%b/%0d/%h exp=0000/%0d/0", k,
                    {s_re[1], s_we[1], s_re[2], s_we[2]}, wcount, s_rdd[1], w0);
            end
        end
        run_req(F3_RS, CSR_MCYCLE, 5'd0, 5'd7, 32'h0, 3, 0, 0, 0);
        total++;
        if ({s_re[1], s_done[2], s_ill[2], s_rdd[2]} !== {3'b110, 32'h0000_1234}) begin
            bad++; $display("FAIL ro_read got=%b%b%b/%h exp=110/00001234",
                s_re[1], s_done[2], s_ill[2], s_rdd[2]);
        end
    endtask

    task automatic test_csrrwi_rd0();
        run_req(F3_RWI, CSR_ALUCSR, 5'h05, 5'd0, 32'hFFFF_FFFF, 3, 0, 0, 0);
        total++;
        if ({s_re[1], s_we[1], s_wd[1]} !== {2'b01, 32'h0000_0005}) begin
            bad++; $display("FAIL rwi_write got=%b%b/%h exp=01/00000005", s_re[1], s_we[1], s_wd[1]);
        end
        total++;
        if ({s_done[1], s_done[2], s_rdd[2]} !== {2'b01, 32'h0}) begin
            bad++; $display("FAIL rwi_done got=%b%b/%h exp=01/0", s_done[1], s_done[2], s_rdd[2]);
        end
        total++;
        if (alu_q !== 32'h0000_0005) begin
            bad++; $display("FAIL rwi_csr_value got=%h exp=00000005", alu_q);
        end
    endtask

    task automatic test_kill();
        int w0;
        w0 = wcount;
        run_req(F3_RW, CSR_ALUCSR, 5'd2, 5'd5, 32'h1111_1111, 4, 1, 0, 0);
        total++;
        if ({s_re[1], s_busy[2], s_we[2], s_done[2], s_done[3], s_done[4]} !== 6'b100000) begin
            bad++; $display("FAIL kill_read got=%b exp=100000",
                {s_re[1], s_busy[2], s_we[2], s_done[2], s_done[3], s_done[4]});
        end
        total++;
        if (wcount !== w0 || alu_q !== 32'h0000_0005) begin
            bad++; $display("FAIL kill_nowrite got=%0d/%h exp=%0d/00000005", wcount, alu_q, w0);
        end
        start = 1'b1; kill = 1'b1; funct3 = F3_RW; csr_index = CSR_ALUCSR; rd_index = 5'd5;
        @(posedge clk); #1;
        start = 1'b0; kill = 1'b0;
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL kill_start_idle got=%b exp=0", busy);
        end
        run_req(F3_RW, CSR_ALUCSR, 5'd2, 5'd5, 32'h2222_2222, 4, 2, 0, 0);
        total++;
        if ({s_we[2], s_done[3], s_rdd[3], alu_q} !== {2'b11, 32'h0000_0005, 32'h2222_2222}) begin
            bad++; $display("FAIL kill_write_ignored got=%b%b/%h/%h exp=11/00000005/22222222",
                s_we[2], s_done[3], s_rdd[3], alu_q);
        end
    endtask

    task automatic test_reset_mid();
        run_req(F3_RW, CSR_DIVCSR, 5'd2, 5'd5, 32'h3333_3333, 4, 0, 2, 0);
        total++;
        if (s_we[2] !== 1'b1) begin
            bad++; $display("FAIL rstmid_in_write got=%b exp=1", s_we[2]);
        end
        total++;
        if ({s_re[3], s_we[3], s_busy[3], s_done[3], s_ill[3], s_we[4], s_done[4]} !== 7'b0 ||
            s_rdd[3] !== 32'h0) begin
            bad++; $display("FAIL rstmid_cleared got=%b/%h exp=0000000/0",
                {s_re[3], s_we[3], s_busy[3], s_done[3], s_ill[3], s_we[4], s_done[4]}, s_rdd[3]);
        end
    endtask

    task automatic test_back_to_back();
        wr_csr(CSR_DIVCSR, 32'h0000_0F00);
        run_req(F3_RS, CSR_DIVCSR, 5'd4, 5'd7, 32'h0000_00FF, 3, 0, 0, 1);
        total++;
        if ({s_we[2], s_wd[2], s_done[3], s_rdd[3]} !== {1'b1, 32'h0000_0FFF, 1'b1, 32'h0000_0F00}) begin
            bad++; $display("FAIL b2b_first got=%b/%h/%b/%h exp=1/00000fff/1/00000f00",
                s_we[2], s_wd[2], s_done[3], s_rdd[3]);
        end
        run_req(F3_RC, CSR_DIVCSR, 5'd4, 5'd7, 32'h0000_000F, 4, 0, 0, 0);
        total++;
        if ({s_re[1], s_wd[2], s_done[3], s_rdd[3]} !== {1'b1, 32'h0000_0FF0, 1'b1, 32'h0000_0FFF}) begin
            bad++; $display("FAIL b2b_second got=%b/%h/%b/%h exp=1/00000ff0/1/00000fff",
                s_re[1], s_wd[2], s_done[3], s_rdd[3]);
        end
        total++;
        if (div_q !== 32'h0000_0FF0 || alu_q !== 32'h2222_2222) begin
            bad++; $display("FAIL b2b_csr_values got=%h/%h exp=00000ff0/22222222", div_q, alu_q);
        end
    endtask

    initial begin
        test_reset();
        test_csrrw();
        test_csrrs();
        test_csrrs_x0();
        test_csrrci();
        test_illegal();
        test_csrrwi_rd0();
        test_kill();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
